// File: rtl/hub75_scan_ctrl.sv
// hub75_scan_ctrl: row-pair scan sequencer for a 64x32 HUB75 panel.
// Shifts one row pair out of a combinational frame buffer, then latches and displays it.
module hub75_scan_ctrl #(
   parameter int WIDTH     = 64,
   parameter int ON_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic [5:0] x,
   output logic [4:0] y1,
   output logic [4:0] y2,
   input  logic [2:0] c1,
   input  logic [2:0] c2,
   output logic [2:0] rgb1,
   output logic [2:0] rgb2,
   output logic       panel_clk,
   output logic       lat,
   output logic       oe_n,
   output logic [3:0] addr,
   output logic       busy,
   output logic       frame_done
);
   typedef enum logic [2:0] {IDLE, PREP, SETUP, HIGH, BLANK, LATCH, DISPLAY} state_t;
   localparam logic [5:0]  XLAST  = 6'(WIDTH - 1);
   localparam logic [15:0] ONLAST = 16'(ON_CYCLES - 1);
   state_t      state;
   logic [3:0]  row;
   logic [15:0] cnt;
   logic        last;
   assign y1 = {1'b0, row};
   assign y2 = {1'b1, row};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         row        <= 4'd0;
         cnt        <= 16'd0;
         last       <= 1'b0;
         x          <= 6'd0;
         rgb1       <= 3'd0;
         rgb2       <= 3'd0;
         panel_clk  <= 1'b0;
         lat        <= 1'b0;
         oe_n       <= 1'b1;
         addr       <= 4'd0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: if (en) begin
               state <= PREP;
               busy  <= 1'b1;
            end
            PREP: begin
               state <= SETUP;
               rgb1  <= c1;
               rgb2  <= c2;
            end
            SETUP: begin
               state     <= HIGH;
               panel_clk <= 1'b1;
               last      <= x == XLAST;
               x         <= x == XLAST ? x : x + 6'd1;
            end
            // the pixel flagged as last was the one just clocked in
            HIGH: begin
               panel_clk <= 1'b0;
               state     <= last ? BLANK : SETUP;
               x         <= last ? 6'd0 : x;
               rgb1      <= last ? rgb1 : c1;
               rgb2      <= last ? rgb2 : c2;
            end
            BLANK: begin
               state <= LATCH;
               lat   <= 1'b1;
               addr  <= row;
            end
            LATCH: begin
               state <= DISPLAY;
               lat   <= 1'b0;
               oe_n  <= 1'b0;
               cnt   <= 16'd0;
            end
            DISPLAY: if (cnt == ONLAST) begin
               oe_n       <= 1'b1;
               row        <= row + 4'd1;
               frame_done <= row == 4'd15;
               state      <= en ? PREP : IDLE;
               busy       <= en;
            end else
               cnt <= cnt + 16'd1;
            default: state <= IDLE;
         endcase
      end
endmodule
